// File: rtl/packet_rx_parser_if.sv
// ============================================================================
// Module : packet_rx_parser_if
// Bundles the framed radio word stream and the decoded header outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface packet_rx_parser_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] in_word;
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic                  rssi_busy;

  logic [2:0]            fPacketType;
  logic [WORD_WIDTH-1:0] fSourceID;
  logic [WORD_WIDTH-1:0] destinationID;
  logic [WORD_WIDTH-1:0] fHopsFromCH;
  logic [WORD_WIDTH-1:0] fChosenCH;
  logic [WORD_WIDTH-1:0] fTimeslot;
  logic [3:0]            fPayloadLen;
  logic                  pkt_strobe;
  logic                  rx_err;
  logic                  channel_clear;

  modport master (
    output in_word, in_valid, in_sop, in_eop, rssi_busy,
    input  fPacketType, fSourceID, destinationID, fHopsFromCH, fChosenCH,
           fTimeslot, fPayloadLen, pkt_strobe, rx_err, channel_clear
  );

  modport slave (
    input  in_word, in_valid, in_sop, in_eop, rssi_busy,
    output fPacketType, fSourceID, destinationID, fHopsFromCH, fChosenCH,
           fTimeslot, fPayloadLen, pkt_strobe, rx_err, channel_clear
  );
endinterface

`default_nettype wire

// File: rtl/packet_rx_parser.sv
// ============================================================================
// Module : packet_rx_parser
// Checks framed packets, decodes the 6-word header and drives carrier sense.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_rx_parser #(
  parameter int WORD_WIDTH  = 16,
  parameter int MAX_PAYLOAD = 8,
  parameter int CCA_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  packet_rx_parser_if.slave   rx
);

  localparam int         CNT_W     = $clog2(CCA_CYCLES + 1);
  localparam logic [2:0] IDLE_TYPE = 3'b111;
  localparam logic [3:0] MAXP      = 4'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] CCA_MAX = CNT_W'(CCA_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DONE    = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [2:0] sh_type_q, sh_type_d;
  logic [4:0][WORD_WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic good_d, bad_d;
  logic [3:0] plen_d;
  logic [3:0] pcnt_inc;

  logic [2:0]            ptype_q;
  logic [WORD_WIDTH-1:0] src_q, dst_q, hops_q, ch_q, ts_q;
  logic [3:0]            plen_q;
  logic                  strobe_q, err_q, clear_q;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    sh_type_d = sh_type_q;
    sh_d      = sh_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    plen_d    = 4'd0;
    pcnt_inc  = pcnt_q + 4'd1;

    if (rx.in_valid && rx.in_sop) begin
      // A sop always starts a new packet; any packet still open is dropped.
      bad_d     = (state_q == S_HDR) || (state_q == S_PAYLOAD) ||
                  (state_q == S_DROP) || rx.in_eop;
      sh_type_d = rx.in_word[2:0];
      wcnt_d    = 3'd1;
      pcnt_d    = 4'd0;
      state_d   = rx.in_eop ? S_IDLE : S_HDR;
    end else if (rx.in_valid) begin
      case (state_q)
        S_HDR: begin
          sh_d[wcnt_q - 3'd1] = rx.in_word;
          if (wcnt_q == 3'd5) begin
            if (!rx.in_eop) begin
              state_d = S_PAYLOAD;
            end else if (sh_type_q == IDLE_TYPE) begin
              bad_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              good_d  = 1'b1;
              state_d = S_DONE;
            end
          end else if (rx.in_eop) begin
            bad_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
        S_PAYLOAD: begin
          if (rx.in_eop) begin
            if (pcnt_inc <= MAXP && sh_type_q != IDLE_TYPE) begin
              good_d  = 1'b1;
              plen_d  = pcnt_inc;
              state_d = S_DONE;
            end else begin
              bad_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else if (pcnt_inc > MAXP) begin
            pcnt_d  = MAXP + 4'd1;
            state_d = S_DROP;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        S_DROP: begin
          if (rx.in_eop) begin
            bad_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end

    if (rx.rssi_busy || rx.in_valid || state_q != S_IDLE) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CCA_MAX) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 3'd0;
      pcnt_q     <= 4'd0;
      sh_type_q  <= 3'd0;
      sh_q       <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
      sh_type_q  <= sh_type_d;
      sh_q       <= sh_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Fields are loaded from the next-shadow so word 5 arriving with eop is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptype_q  <= IDLE_TYPE;
      src_q    <= '0;
      dst_q    <= '0;
      hops_q   <= '0;
      ch_q     <= '0;
      ts_q     <= '0;
      plen_q   <= 4'd0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      strobe_q <= good_d;
      err_q    <= bad_d;
      ptype_q  <= good_d ? sh_type_q : IDLE_TYPE;
      clear_q  <= (idle_cnt_d == CCA_MAX);
      if (good_d) begin
        src_q  <= sh_d[0];
        dst_q  <= sh_d[1];
        hops_q <= sh_d[2];
        ch_q   <= sh_d[3];
        ts_q   <= sh_d[4];
        plen_q <= plen_d;
      end
    end
  end

  assign rx.fPacketType   = ptype_q;
  assign rx.fSourceID     = src_q;
  assign rx.destinationID = dst_q;
  assign rx.fHopsFromCH   = hops_q;
  assign rx.fChosenCH     = ch_q;
  assign rx.fTimeslot     = ts_q;
  assign rx.fPayloadLen   = plen_q;
  assign rx.pkt_strobe    = strobe_q;
  assign rx.rx_err        = err_q;
  assign rx.channel_clear = clear_q;

endmodule

`default_nettype wire

// File: tb/tb_packet_rx_parser.sv
// ============================================================================
// Module : tb_packet_rx_parser
// Directed table, corner sequences and random packets against a packet-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_packet_rx_parser;

  localparam int WW   = 16;
  localparam int MAXP = 8;
  localparam int CCA  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_rx_parser_if #(.WORD_WIDTH(WW)) bus ();

  packet_rx_parser #(
    .WORD_WIDTH (WW),
    .MAX_PAYLOAD(MAXP),
    .CCA_CYCLES (CCA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level reference: collects words since sop and judges the whole packet at eop.
  bit          m_inprog;
  bit          m_done;
  logic [15:0] m_q[$];
  int          m_run;
  logic [15:0] m_f[5];
  int          m_len;
  bit          e_strobe, e_err, e_clear;
  logic [2:0]  e_type;

  task automatic model(input bit r, v, s, e, input logic [15:0] w, input bit busy);
    if (r) begin
      m_inprog = 0; m_done = 0; m_run = 0; m_len = 0;
      m_q.delete();
      for (int i = 0; i < 5; i++) m_f[i] = '0;
      e_strobe = 0; e_err = 0; e_clear = 0; e_type = 3'b111;
    end else begin
      if (!busy && !v && !m_inprog && !m_done) m_run = (m_run < CCA) ? m_run + 1 : CCA;
      else m_run = 0;
      e_clear  = (m_run == CCA);
      e_strobe = 0; e_err = 0; e_type = 3'b111;
      if (v) begin
        if (s) begin
          if (m_inprog) e_err = 1;
          m_q.delete();
          m_q.push_back(w);
          m_inprog = 1;
        end else if (m_inprog) begin
          m_q.push_back(w);
        end
        if (e && m_inprog) begin
          if (m_q.size() < 6 || m_q.size() - 6 > MAXP || m_q[0][2:0] == 3'b111) begin
            e_err = 1;
          end else begin
            e_strobe = 1;
            e_type   = m_q[0][2:0];
            for (int i = 0; i < 5; i++) m_f[i] = m_q[i+1];
            m_len = m_q.size() - 6;
          end
          m_inprog = 0;
          m_q.delete();
        end
      end
      m_done = e_strobe;
    end
  endtask

  task automatic step(input bit r, v, s, e, input logic [15:0] w, input bit busy);
    rst           = r;
    bus.in_valid  = v;
    bus.in_sop    = s;
    bus.in_eop    = e;
    bus.in_word   = w;
    bus.rssi_busy = busy;
    model(r, v, s, e, w, busy);
    @(posedge clk);
    @(negedge clk);
    chk("strobe", 64'(bus.pkt_strobe),    64'(e_strobe));
    chk("rx_err", 64'(bus.rx_err),        64'(e_err));
    chk("ptype",  64'(bus.fPacketType),   64'(e_type));
    chk("clear",  64'(bus.channel_clear), 64'(e_clear));
    chk("src",    64'(bus.fSourceID),     64'(m_f[0]));
    chk("dst",    64'(bus.destinationID), 64'(m_f[1]));
    chk("hops",   64'(bus.fHopsFromCH),   64'(m_f[2]));
    chk("chosen", 64'(bus.fChosenCH),     64'(m_f[3]));
    chk("tslot",  64'(bus.fTimeslot),     64'(m_f[4]));
    chk("plen",   64'(bus.fPayloadLen),   64'(m_len));
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, busy);
  endtask

  typedef struct {
    bit          v, s, e;
    logic [15:0] w;
    bit          xs, xe;
    logic [2:0]  xt;
    bit          cf;
    logic [15:0] xh;
    logic [3:0]  xl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, s, e, input logic [15:0] w, input bit xs, xe,
                     input logic [2:0] xt, input bit cf, input logic [15:0] xh,
                     input logic [3:0] xl);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.w = w;
    r.xs = xs; r.xe = xe; r.xt = xt; r.cf = cf; r.xh = xh; r.xl = xl;
    tbl.push_back(r);
  endtask

  task automatic aw(input bit s, e, input logic [15:0] w);
    add(1, s, e, w, 0, 0, 3'b111, 0, 16'h0, 4'd0);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0;
    bus.in_word = '0; bus.rssi_busy = 0;

    // Good header-only packet, type 010
    aw(1, 0, 16'hABC2); aw(0, 0, 16'h0011); aw(0, 0, 16'h0022);
    aw(0, 0, 16'd2);    aw(0, 0, 16'd7);
    add(1, 0, 1, 16'h0005, 1, 0, 3'b010, 1, 16'd2, 4'd0);
    add(0, 0, 0, 16'h0,    0, 0, 3'b111, 1, 16'd2, 4'd0);
    // Data packet, type 101, 3 payload words
    aw(1, 0, 16'h0005); aw(0, 0, 16'h0101); aw(0, 0, 16'h0102);
    aw(0, 0, 16'd4);    aw(0, 0, 16'd3);    aw(0, 0, 16'd1);
    aw(0, 0, 16'h00D0); aw(0, 0, 16'h00D1);
    add(1, 0, 1, 16'h00D2, 1, 0, 3'b101, 1, 16'd4, 4'd3);
    // 6+9 words: overflow, fields unchanged
    aw(1, 0, 16'h0001);
    for (int i = 0; i < 13; i++) aw(0, 0, 16'(i + 100));
    add(1, 0, 1, 16'h00EE, 0, 1, 3'b111, 1, 16'd4, 4'd3);
    // Short packet
    aw(1, 0, 16'h0002); aw(0, 0, 16'h0033);
    add(1, 0, 1, 16'h0044, 0, 1, 3'b111, 1, 16'd4, 4'd3);
    // sop mid-header restarts; second packet decodes
    aw(1, 0, 16'h0003); aw(0, 0, 16'h0001); aw(0, 0, 16'h0002);
    add(1, 1, 0, 16'h0006, 0, 1, 3'b111, 1, 16'd4, 4'd3);
    aw(0, 0, 16'h0A01); aw(0, 0, 16'h0A02); aw(0, 0, 16'd9); aw(0, 0, 16'h0A04);
    add(1, 0, 1, 16'h0A05, 1, 0, 3'b110, 1, 16'd9, 4'd0);
    // Back-to-back: next sop lands in the strobe cycle
    aw(1, 0, 16'h0001); aw(0, 0, 16'h0B01); aw(0, 0, 16'h0B02);
    aw(0, 0, 16'd5);    aw(0, 0, 16'h0B04);
    add(1, 0, 1, 16'h0B05, 1, 0, 3'b001, 1, 16'd5, 4'd0);
    add(1, 1, 0, 16'h0004, 0, 0, 3'b111, 1, 16'd5, 4'd0);
    aw(0, 0, 16'h0C01); aw(0, 0, 16'h0C02); aw(0, 0, 16'd12); aw(0, 0, 16'h0C04);
    add(1, 0, 1, 16'h0C05, 1, 0, 3'b100, 1, 16'd12, 4'd0);
    // Type 111 is dropped
    aw(1, 0, 16'hFFFF); aw(0, 0, 16'h0D01); aw(0, 0, 16'h0D02);
    aw(0, 0, 16'd99);   aw(0, 0, 16'h0D04);
    add(1, 0, 1, 16'h0D05, 0, 1, 3'b111, 1, 16'd12, 4'd0);
    add(0, 0, 0, 16'h0,    0, 0, 3'b111, 1, 16'd12, 4'd0);

    step(1, 0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    chk("rst_ptype", 64'(bus.fPacketType), 64'(3'b111));
    chk("rst_strobe", 64'(bus.pkt_strobe), 64'd0);

    foreach (tbl[k]) begin
      step(0, tbl[k].v, tbl[k].s, tbl[k].e, tbl[k].w, 1'b0);
      chk("tbl_strobe", 64'(bus.pkt_strobe),  64'(tbl[k].xs));
      chk("tbl_err",    64'(bus.rx_err),      64'(tbl[k].xe));
      chk("tbl_ptype",  64'(bus.fPacketType), 64'(tbl[k].xt));
      if (tbl[k].cf) begin
        chk("tbl_hops", 64'(bus.fHopsFromCH), 64'(tbl[k].xh));
        chk("tbl_plen", 64'(bus.fPayloadLen), 64'(tbl[k].xl));
      end
    end

    // Carrier sense
    step(0, 0, 0, 0, 16'h0, 1);
    idle(15, 0);
    chk("cca_15", 64'(bus.channel_clear), 64'd0);
    idle(1, 0);
    chk("cca_16", 64'(bus.channel_clear), 64'd1);
    step(0, 0, 0, 0, 16'h0, 1);
    chk("cca_busy", 64'(bus.channel_clear), 64'd0);
    idle(15, 0);
    chk("cca_re15", 64'(bus.channel_clear), 64'd0);
    idle(1, 0);
    chk("cca_re16", 64'(bus.channel_clear), 64'd1);
    step(0, 1, 0, 0, 16'h1234, 0);
    chk("cca_valid", 64'(bus.channel_clear), 64'd0);

    // Reset during payload
    step(0, 1, 1, 0, 16'h0002, 0);
    for (int i = 1; i < 6; i++) step(0, 1, 0, 0, 16'(i + 16'h0E00), 0);
    step(0, 1, 0, 0, 16'h0E10, 0);
    step(0, 1, 0, 0, 16'h0E11, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    chk("mrst_ptype",  64'(bus.fPacketType), 64'(3'b111));
    chk("mrst_hops",   64'(bus.fHopsFromCH), 64'd0);
    chk("mrst_strobe", 64'(bus.pkt_strobe),  64'd0);
    chk("mrst_err",    64'(bus.rx_err),      64'd0);
    step(0, 1, 0, 1, 16'h0E12, 0);
    chk("mrst_tail_err", 64'(bus.rx_err), 64'd0);
    step(0, 1, 1, 0, 16'h0003, 0);
    step(0, 1, 0, 0, 16'h0F01, 0);
    step(0, 1, 0, 0, 16'h0F02, 0);
    step(0, 1, 0, 0, 16'd6,    0);
    step(0, 1, 0, 0, 16'h0F04, 0);
    step(0, 1, 0, 1, 16'h0F05, 0);
    chk("post_rst_strobe", 64'(bus.pkt_strobe),  64'd1);
    chk("post_rst_ptype",  64'(bus.fPacketType), 64'(3'b011));
    chk("post_rst_hops",   64'(bus.fHopsFromCH), 64'd6);

    // Random packets with gaps, truncation, junk words and busy noise
    for (int p = 0; p < 250; p++) begin
      int  n;
      bit  trunc;
      if ($urandom_range(0, 9) == 0) idle(CCA + 4, 0);
      else idle($urandom_range(0, 3), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0)
        step(0, 1, 0, $urandom_range(0, 1), 16'($urandom), 0);
      n     = 1 + $urandom_range(0, 16);
      trunc = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 16'h0, $urandom_range(0, 7) == 0);
        step(0, 1, i == 0, (i == n - 1) && !trunc, 16'($urandom), $urandom_range(0, 7) == 0);
      end
    end
    idle(3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
